// File: rtl/ooo_pkg.sv
// ooo_pkg: shared definitions for the out-of-order issue/complete path.
// Used by the reservation station and by fu_completion_tracker.
//   TAG_W   : physical register tag width
//   OP_*    : RV opcodes the back end cares about
//   fu_e    : functional unit index (ALU0, ALU1, MEM); value 3 is illegal
//   is_store: true for ops that retire without producing a tag
package ooo_pkg;
  localparam int TAG_W  = 6;
  localparam int NUM_FU = 3;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MEM  = 2'd2
  } fu_e;

  function automatic logic is_store(input logic [6:0] op);
    return op == OP_SW;
  endfunction
endpackage

// File: rtl/fu_completion_tracker_if.sv
// fu_completion_tracker_if: issue / availability / writeback bundle between
// the reservation station (master) and the completion tracker (slave).
//   iss_*_1/2  : two issue ports (valid, dest tag, opcode, target unit)
//   fu_avail   : per-unit "may accept an issue this cycle"
//   wb_*_1/2   : two registered wakeup broadcast slots
interface fu_completion_tracker_if #(parameter int TAG_W = 6);
  logic             iss_valid_1;
  logic [TAG_W-1:0] iss_rd_1;
  logic [6:0]       iss_op_1;
  logic [1:0]       iss_fu_1;
  logic             iss_valid_2;
  logic [TAG_W-1:0] iss_rd_2;
  logic [6:0]       iss_op_2;
  logic [1:0]       iss_fu_2;
  logic [2:0]       fu_avail;
  logic             wb_valid_1;
  logic [TAG_W-1:0] wb_rd_1;
  logic             wb_valid_2;
  logic [TAG_W-1:0] wb_rd_2;

  modport master (
    output iss_valid_1, iss_rd_1, iss_op_1, iss_fu_1,
    output iss_valid_2, iss_rd_2, iss_op_2, iss_fu_2,
    input  fu_avail, wb_valid_1, wb_rd_1, wb_valid_2, wb_rd_2
  );

  modport slave (
    input  iss_valid_1, iss_rd_1, iss_op_1, iss_fu_1,
    input  iss_valid_2, iss_rd_2, iss_op_2, iss_fu_2,
    output fu_avail, wb_valid_1, wb_rd_1, wb_valid_2, wb_rd_2
  );
endinterface

// File: rtl/fu_slot.sv
// fu_slot: occupancy model of one functional unit.
//   clk, rst_n : clock, async active-low reset
//   i_flush    : drop the in-flight op
//   i_issue    : op accepted this edge (only asserted while idle)
//   i_rd       : dest tag of the issued op
//   i_store    : issued op produces no tag
//   i_grant    : completion queue has room for this unit's tag this edge
//   o_busy     : unit holds an op (drives ~fu_avail)
//   o_req      : result ready and waiting for a queue entry
//   o_rd       : held dest tag
// A finished non-store op that is not granted stays busy with cnt=0 and
// re-requests every cycle.
module fu_slot #(
  parameter int LAT   = 1,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_issue,
  input  logic [TAG_W-1:0] i_rd,
  input  logic             i_store,
  input  logic             i_grant,
  output logic             o_busy,
  output logic             o_req,
  output logic [TAG_W-1:0] o_rd
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic             r_busy;
  logic             r_store;
  logic [CW-1:0]    r_cnt;
  logic [TAG_W-1:0] r_rd;
  logic             w_done;
  logic             w_retire;

  assign w_done   = r_busy && (r_cnt == '0);
  assign w_retire = w_done && (r_store || i_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_store <= 1'b0;
      r_cnt   <= '0;
      r_rd    <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_issue) begin
      r_busy  <= 1'b1;
      r_cnt   <= CW'(LAT - 1);
      r_rd    <= i_rd;
      r_store <= i_store;
    end else if (w_retire) begin
      r_busy <= 1'b0;
    end else if (r_busy && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = r_busy;
  assign o_req  = w_done && !r_store;
  assign o_rd   = r_rd;
endmodule

// File: rtl/fu_completion_tracker.sv
// fu_completion_tracker: consumer end of the reservation-station issue
// interface. Accepts up to 2 ops/cycle into ALU0/ALU1/MEM, models their
// latency, queues produced tags and broadcasts up to 2 wakeups/cycle.
//   clk, rst_n : clock, async active-low reset
//   flush      : sync squash of all in-flight state (proto_err survives)
//   bus        : slave side of fu_completion_tracker_if
//   proto_err  : sticky issue-protocol violation
module fu_completion_tracker
  import ooo_pkg::*;
#(
  parameter int TAG_W    = 6,
  parameter int ALU_LAT  = 1,
  parameter int MEM_LAT  = 3,
  parameter int CQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  fu_completion_tracker_if.slave   bus,
  output logic                     proto_err
);
  localparam int PW = $clog2(CQ_DEPTH);
  localparam int AW = PW + 1;

  logic [NUM_FU-1:0]             w_busy, w_req, w_grant, w_issue, w_store;
  logic [NUM_FU-1:0][TAG_W-1:0]  w_slot_rd, w_iss_rd;
  logic [3:0]                    w_avail4;
  logic                          w_same, w_acc1, w_acc2, w_err1, w_err2;

  // ---------------- issue decode ----------------
  // Bit 3 is the illegal unit: never available, so fu=3 is a violation.
  assign w_avail4 = {1'b0, ~w_busy};
  assign w_same   = bus.iss_valid_1 && bus.iss_valid_2 && (bus.iss_fu_1 == bus.iss_fu_2);
  assign w_acc1   = !flush && bus.iss_valid_1 && w_avail4[bus.iss_fu_1];
  assign w_acc2   = !flush && bus.iss_valid_2 && w_avail4[bus.iss_fu_2] && !w_same;
  assign w_err1   = !flush && bus.iss_valid_1 && !w_avail4[bus.iss_fu_1];
  assign w_err2   = !flush && bus.iss_valid_2 && (!w_avail4[bus.iss_fu_2] || w_same);

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    logic w_hit1, w_hit2;
    assign w_hit1      = w_acc1 && (bus.iss_fu_1 == 2'(g));
    assign w_hit2      = w_acc2 && (bus.iss_fu_2 == 2'(g));
    assign w_issue[g]  = w_hit1 || w_hit2;
    assign w_iss_rd[g] = w_hit1 ? bus.iss_rd_1 : bus.iss_rd_2;
    assign w_store[g]  = w_hit1 ? is_store(bus.iss_op_1) : is_store(bus.iss_op_2);

    fu_slot #(
      .LAT   ((g == int'(FU_MEM)) ? MEM_LAT : ALU_LAT),
      .TAG_W (TAG_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_issue (w_issue[g]),
      .i_rd    (w_iss_rd[g]),
      .i_store (w_store[g]),
      .i_grant (w_grant[g]),
      .o_busy  (w_busy[g]),
      .o_req   (w_req[g]),
      .o_rd    (w_slot_rd[g])
    );
  end

  assign bus.fu_avail = ~w_busy;

  // ---------------- completion queue ----------------
  logic [TAG_W-1:0] r_mem [CQ_DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW-1:0]    w_occ_v, w_rd_p1;
  logic [AW-1:0]    w_wa_mem, w_wa_alu0, w_wa_alu1, w_wr_nxt;
  int               w_occ, w_pops, w_free;

  // Entries popped this edge free room for enqueues in the same edge.
  // Grants walk MEM, ALU0, ALU1 and each takes the next free entry.
  always_comb begin
    w_occ_v = r_wr - r_rd;
    w_occ   = int'(w_occ_v);
    w_pops  = (w_occ > 2) ? 2 : w_occ;
    w_free  = CQ_DEPTH - w_occ + w_pops;
    w_grant = '0;
    w_grant[FU_MEM]  = w_req[FU_MEM] && (w_free > 0);
    w_grant[FU_ALU0] = w_req[FU_ALU0] && (w_free > int'(w_grant[FU_MEM]));
    w_grant[FU_ALU1] = w_req[FU_ALU1] &&
                       (w_free > int'(w_grant[FU_MEM]) + int'(w_grant[FU_ALU0]));
    w_wa_mem  = r_wr;
    w_wa_alu0 = w_wa_mem  + AW'(w_grant[FU_MEM]);
    w_wa_alu1 = w_wa_alu0 + AW'(w_grant[FU_ALU0]);
    w_wr_nxt  = w_wa_alu1 + AW'(w_grant[FU_ALU1]);
    w_rd_p1   = r_rd + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_grant[FU_MEM])  r_mem[w_wa_mem[PW-1:0]]  <= w_slot_rd[FU_MEM];
    if (w_grant[FU_ALU0]) r_mem[w_wa_alu0[PW-1:0]] <= w_slot_rd[FU_ALU0];
    if (w_grant[FU_ALU1]) r_mem[w_wa_alu1[PW-1:0]] <= w_slot_rd[FU_ALU1];
  end

  logic             r_wb_v1, r_wb_v2, r_perr;
  logic [TAG_W-1:0] r_wb_rd1, r_wb_rd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_wb_v1  <= 1'b0;
      r_wb_v2  <= 1'b0;
      r_wb_rd1 <= '0;
      r_wb_rd2 <= '0;
      r_perr   <= 1'b0;
    end else if (flush) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_wb_v1  <= 1'b0;
      r_wb_v2  <= 1'b0;
      r_wb_rd1 <= '0;
      r_wb_rd2 <= '0;
    end else begin
      r_wr     <= w_wr_nxt;
      r_rd     <= r_rd + AW'(w_pops);
      r_wb_v1  <= w_pops >= 1;
      r_wb_v2  <= w_pops >= 2;
      r_wb_rd1 <= (w_pops >= 1) ? r_mem[r_rd[PW-1:0]]    : '0;
      r_wb_rd2 <= (w_pops >= 2) ? r_mem[w_rd_p1[PW-1:0]] : '0;
      r_perr   <= r_perr || w_err1 || w_err2;
    end
  end

  assign bus.wb_valid_1 = r_wb_v1;
  assign bus.wb_rd_1    = r_wb_rd1;
  assign bus.wb_valid_2 = r_wb_v2;
  assign bus.wb_rd_2    = r_wb_rd2;
  assign proto_err      = r_perr;
endmodule

// File: tb/tb_fu_completion_tracker.sv
// Bench for fu_completion_tracker: directed issue sequences; expected tags
// are queued at issue time and a negedge monitor checks every broadcast.
// Two instances: CQ_DEPTH=4 (main) and CQ_DEPTH=2 (back-pressure).
module tb_fu_completion_tracker;
  import ooo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic perr_a, perr_b;
  int   n_vec = 0;
  int   n_err = 0;
  logic [5:0] expa[$];
  logic [5:0] expb[$];

  always #5 clk = ~clk;

  fu_completion_tracker_if #(.TAG_W(6)) ifa();
  fu_completion_tracker_if #(.TAG_W(6)) ifb();

  fu_completion_tracker #(.TAG_W(6), .ALU_LAT(1), .MEM_LAT(3), .CQ_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa), .proto_err(perr_a));

  fu_completion_tracker #(.TAG_W(6), .ALU_LAT(1), .MEM_LAT(3), .CQ_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb), .proto_err(perr_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input bit b, input logic [5:0] got, input string nm);
    logic [5:0] e;
    n_vec++;
    if (b ? (expb.size() == 0) : (expa.size() == 0)) begin
      n_err++;
      $display("FAIL %s: unexpected tag %0d broadcast", nm, got);
    end else begin
      if (b) e = expb.pop_front();
      else   e = expa.pop_front();
      if (e !== got) begin
        n_err++;
        $display("FAIL %s: got tag %0d expected %0d", nm, got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ifa.wb_valid_1) sb_pop(1'b0, ifa.wb_rd_1, "sb_a.wb1");
    if (ifa.wb_valid_2) sb_pop(1'b0, ifa.wb_rd_2, "sb_a.wb2");
    if (ifb.wb_valid_1) sb_pop(1'b1, ifb.wb_rd_1, "sb_b.wb1");
    if (ifb.wb_valid_2) sb_pop(1'b1, ifb.wb_rd_2, "sb_b.wb2");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.iss_valid_1 = 0; ifa.iss_rd_1 = '0; ifa.iss_op_1 = '0; ifa.iss_fu_1 = '0;
    ifa.iss_valid_2 = 0; ifa.iss_rd_2 = '0; ifa.iss_op_2 = '0; ifa.iss_fu_2 = '0;
    ifb.iss_valid_1 = 0; ifb.iss_rd_1 = '0; ifb.iss_op_1 = '0; ifb.iss_fu_1 = '0;
    ifb.iss_valid_2 = 0; ifb.iss_rd_2 = '0; ifb.iss_op_2 = '0; ifb.iss_fu_2 = '0;
  endtask

  // b selects the instance, p the issue port
  task automatic iss(input bit b, input int p, input logic [5:0] rd,
                     input logic [6:0] op, input logic [1:0] fu);
    if (!b && p == 1) begin ifa.iss_valid_1 = 1; ifa.iss_rd_1 = rd; ifa.iss_op_1 = op; ifa.iss_fu_1 = fu; end
    if (!b && p == 2) begin ifa.iss_valid_2 = 1; ifa.iss_rd_2 = rd; ifa.iss_op_2 = op; ifa.iss_fu_2 = fu; end
    if ( b && p == 1) begin ifb.iss_valid_1 = 1; ifb.iss_rd_1 = rd; ifb.iss_op_1 = op; ifb.iss_fu_1 = fu; end
    if ( b && p == 2) begin ifb.iss_valid_2 = 1; ifb.iss_rd_2 = rd; ifb.iss_op_2 = op; ifb.iss_fu_2 = fu; end
  endtask

  initial begin
    idle();
    // reset state
    tick(); tick();
    chk("rst.fu_avail", ifa.fu_avail, 3'b111);
    chk("rst.wb_v1", ifa.wb_valid_1, 0);
    chk("rst.wb_v2", ifa.wb_valid_2, 0);
    chk("rst.perr", perr_a, 0);
    rst_n = 1; tick();

    // reset mid-op: LW rd=20 in flight plus a fu=3 violation, both dropped
    iss(0, 1, 6'd20, OP_LW, FU_MEM); iss(0, 2, 6'd21, OP_R, 2'd3);
    tick(); idle();
    chk("midrst.perr_set", perr_a, 1);
    chk("midrst.mem_busy", ifa.fu_avail[2], 0);
    tick(); rst_n = 0; tick(); tick();
    chk("midrst.fu_avail", ifa.fu_avail, 3'b111);
    chk("midrst.wb_v1", ifa.wb_valid_1, 0);
    chk("midrst.wb_v2", ifa.wb_valid_2, 0);
    chk("midrst.perr", perr_a, 0);
    rst_n = 1;
    repeat (6) tick();

    // ADD rd=5 on ALU0
    iss(0, 1, 6'd5, OP_R, FU_ALU0); expa.push_back(6'd5);
    tick(); idle();
    chk("add.busy_e0", ifa.fu_avail[0], 0);
    tick();
    chk("add.free_e1", ifa.fu_avail[0], 1);
    chk("add.nowb_e1", ifa.wb_valid_1, 0);
    tick();
    chk("add.wb_v1_e2", ifa.wb_valid_1, 1);
    chk("add.wb_rd1_e2", ifa.wb_rd_1, 5);
    chk("add.wb_v2_e2", ifa.wb_valid_2, 0);
    tick();
    chk("add.wb_once", ifa.wb_valid_1, 0);

    // LW rd=9 on MEM
    iss(0, 1, 6'd9, OP_LW, FU_MEM); expa.push_back(6'd9);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("lw.mem_busy", ifa.fu_avail[2], 0);
      tick();
    end
    chk("lw.mem_free_e3", ifa.fu_avail[2], 1);
    chk("lw.nowb_e3", ifa.wb_valid_1, 0);
    tick();
    chk("lw.wb_v1_e4", ifa.wb_valid_1, 1);
    chk("lw.wb_rd1_e4", ifa.wb_rd_1, 9);
    tick();

    // SW on MEM: busy 3 cycles, no broadcast
    iss(0, 1, 6'd4, OP_SW, FU_MEM);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("sw.mem_busy", ifa.fu_avail[2], 0);
      tick();
    end
    chk("sw.mem_free_e3", ifa.fu_avail[2], 1);
    tick();
    chk("sw.nowb_e4", ifa.wb_valid_1, 0);
    tick();

    // LW rd=3 at E0, ADDs rd=1 (ALU0) rd=2 (ALU1) at E2: all retire at E3
    iss(0, 1, 6'd3, OP_LW, FU_MEM); expa.push_back(6'd3);
    tick(); idle(); tick();
    iss(0, 1, 6'd1, OP_R, FU_ALU0); iss(0, 2, 6'd2, OP_I, FU_ALU1);
    expa.push_back(6'd1); expa.push_back(6'd2);
    tick(); idle();
    tick();
    tick();
    chk("mix.wb_v1_e4", ifa.wb_valid_1, 1);
    chk("mix.wb_rd1_e4", ifa.wb_rd_1, 3);
    chk("mix.wb_v2_e4", ifa.wb_valid_2, 1);
    chk("mix.wb_rd2_e4", ifa.wb_rd_2, 1);
    tick();
    chk("mix.wb_v1_e5", ifa.wb_valid_1, 1);
    chk("mix.wb_rd1_e5", ifa.wb_rd_1, 2);
    chk("mix.wb_v2_e5", ifa.wb_valid_2, 0);
    tick();

    // both ports to ALU0: port 1 wins, sticky error
    chk("dual.perr_pre", perr_a, 0);
    iss(0, 1, 6'd7, OP_R, FU_ALU0); iss(0, 2, 6'd8, OP_R, FU_ALU0);
    expa.push_back(6'd7);
    tick(); idle();
    chk("dual.perr", perr_a, 1);
    chk("dual.fu_avail", ifa.fu_avail, 3'b110);
    tick(); tick();
    chk("dual.wb_rd1", ifa.wb_rd_1, 7);
    chk("dual.wb_v2", ifa.wb_valid_2, 0);
    repeat (3) tick();
    chk("dual.perr_sticky", perr_a, 1);

    // flush drops rd=30 in flight and ignores the rd=31 issue; error kept
    iss(0, 1, 6'd30, OP_R, FU_ALU0);
    tick();
    flush = 1; iss(0, 1, 6'd31, OP_R, FU_ALU1);
    tick(); flush = 0; idle();
    chk("flush.fu_avail", ifa.fu_avail, 3'b111);
    chk("flush.perr_kept", perr_a, 1);
    repeat (3) tick();
    chk("flush.nowb", ifa.wb_valid_1, 0);

    // issue to a busy unit
    rst_n = 0; tick(); rst_n = 1;
    chk("busy.perr_pre", perr_a, 0);
    iss(0, 1, 6'd40, OP_LW, FU_MEM); expa.push_back(6'd40);
    tick();
    iss(0, 1, 6'd41, OP_LW, FU_MEM);
    tick(); idle();
    chk("busy.perr", perr_a, 1);
    repeat (5) tick();

    // CQ_DEPTH=2: MEM, ALU0, ALU1 retire together at E3, ALU1 stalls
    iss(1, 1, 6'd10, OP_LW, FU_MEM); expb.push_back(6'd10);
    tick(); idle(); tick();
    iss(1, 1, 6'd11, OP_R, FU_ALU0); iss(1, 2, 6'd12, OP_R, FU_ALU1);
    expb.push_back(6'd11); expb.push_back(6'd12);
    tick(); idle();
    tick();
    chk("cq2.stall_avail", ifb.fu_avail, 3'b101);
    iss(1, 1, 6'd13, OP_R, FU_ALU0); expb.push_back(6'd13);
    tick(); idle();
    chk("cq2.wb_rd1_e4", ifb.wb_rd_1, 10);
    chk("cq2.wb_rd2_e4", ifb.wb_rd_2, 11);
    chk("cq2.wb_v2_e4", ifb.wb_valid_2, 1);
    chk("cq2.avail_e4", ifb.fu_avail, 3'b110);
    tick();
    chk("cq2.wb_v1_e5", ifb.wb_valid_1, 1);
    chk("cq2.wb_rd1_e5", ifb.wb_rd_1, 12);
    chk("cq2.wb_v2_e5", ifb.wb_valid_2, 0);
    tick();
    chk("cq2.wb_v1_e6", ifb.wb_valid_1, 1);
    chk("cq2.wb_rd1_e6", ifb.wb_rd_1, 13);
    repeat (3) tick();

    chk("sb_a.drained", expa.size(), 0);
    chk("sb_b.drained", expb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
